// File: rtl/slave_token_receiver_if.sv
// Receive-side token bus between the SIE receive path and the device endpoint controller.
// The slave modport is the token receiver; the master modport is the SIE/controller side.
interface slave_token_receiver_if;
    logic [7:0]  RxData;
    logic        RxDataValid;
    logic        RxSOP;
    logic        RxEOP;
    logic        RxBitStuffErr;
    logic [6:0]  devAddr;
    logic        enable;
    logic        tokenValid;
    logic [3:0]  tokenPID;
    logic [3:0]  tokenEndP;
    logic        SOFRxed;
    logic [10:0] frameNum;
    logic        tokenErr;
    logic        endpMiss;
    logic        sofMissed;

    modport slave (
        input  RxData, RxDataValid, RxSOP, RxEOP, RxBitStuffErr, devAddr, enable,
        output tokenValid, tokenPID, tokenEndP, SOFRxed, frameNum, tokenErr, endpMiss, sofMissed
    );

    modport master (
        output RxData, RxDataValid, RxSOP, RxEOP, RxBitStuffErr, devAddr, enable,
        input  tokenValid, tokenPID, tokenEndP, SOFRxed, frameNum, tokenErr, endpMiss, sofMissed
    );
endinterface

// File: rtl/slave_token_receiver.sv
// Device-side USB token decoder: parses SETUP/IN/OUT/SOF, checks PID and CRC5, matches address/endpoint.
// Optional SOF watchdog enabled by defining TOKEN_RX_SOF_TIMER_EN.
module slave_token_receiver #(
    parameter int NUM_ENDP    = 4,
    parameter int SOF_TIMEOUT = 60500
) (
    input  logic                   clk,
    input  logic                   rst,
    slave_token_receiver_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_B1,
        S_B2,
        S_WAIT_EOP,
        S_CHECK,
        S_DROP
    } state_t;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;

    state_t      r_state;
    logic [3:0]  r_pid;
    logic [7:0]  r_b1;
    logic [7:0]  r_b2;
    logic        r_err;
    logic        r_tokenValid;
    logic [3:0]  r_tokenPID;
    logic [3:0]  r_tokenEndP;
    logic        r_SOFRxed;
    logic [10:0] r_frameNum;
    logic        r_tokenErr;
    logic        r_endpMiss;

    logic [10:0] w_field;
    logic [6:0]  w_addr;
    logic [3:0]  w_endp;
    logic        w_crcOk;
    logic        w_pidOk;
    logic        w_pidKnown;
    logic        w_sofGood;

    // Residual of the 16 bits following the PID, LSB of B1 first, through x^5+x^2+1.
    function automatic logic [4:0] crc5Residual(input logic [15:0] data);
        logic [4:0] crc;
        logic       fb;
        crc = 5'b11111;
        for (int i = 0; i < 16; i++) begin
            fb  = crc[4] ^ data[i];
            crc = {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        return crc;
    endfunction

    assign w_field    = {r_b2[2:0], r_b1};
    assign w_addr     = r_b1[6:0];
    assign w_endp     = {r_b2[2:0], r_b1[7]};
    assign w_crcOk    = (crc5Residual({r_b2, r_b1}) == 5'b01100);
    assign w_pidOk    = (bus.RxData[7:4] == ~bus.RxData[3:0]);
    assign w_pidKnown = (bus.RxData[3:0] == PID_OUT) || (bus.RxData[3:0] == PID_IN) ||
                        (bus.RxData[3:0] == PID_SOF) || (bus.RxData[3:0] == PID_SETUP);
    assign w_sofGood  = (r_state == S_CHECK) && !bus.RxSOP && !r_err && w_crcOk && (r_pid == PID_SOF);

`ifdef TOKEN_RX_SOF_TIMER_EN
    logic [15:0] r_sofTimer;
    logic        r_sofMissed;
    assign bus.sofMissed = r_sofMissed;
`else
    assign bus.sofMissed = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_pid        <= '0;
            r_b1         <= '0;
            r_b2         <= '0;
            r_err        <= 1'b0;
            r_tokenValid <= 1'b0;
            r_tokenPID   <= '0;
            r_tokenEndP  <= '0;
            r_SOFRxed    <= 1'b0;
            r_frameNum   <= '0;
            r_tokenErr   <= 1'b0;
            r_endpMiss   <= 1'b0;
`ifdef TOKEN_RX_SOF_TIMER_EN
            r_sofTimer   <= '0;
            r_sofMissed  <= 1'b0;
`endif
        end else begin
            r_tokenValid <= 1'b0;
            r_SOFRxed    <= 1'b0;
            r_tokenErr   <= 1'b0;
            r_endpMiss   <= 1'b0;
`ifdef TOKEN_RX_SOF_TIMER_EN
            r_sofMissed  <= 1'b0;
`endif
            // A new start of packet always wins and silently discards whatever was in flight.
            if (bus.RxSOP) begin
                r_state <= S_PID;
                r_err   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_IDLE;
                    S_PID: begin
                        if (bus.RxEOP) begin
                            r_err   <= 1'b1;
                            r_state <= S_CHECK;
                        end else if (bus.RxDataValid) begin
                            r_pid <= bus.RxData[3:0];
                            if (!w_pidOk) begin
                                r_err   <= 1'b1;
                                r_state <= S_WAIT_EOP;
                            end else if (w_pidKnown) begin
                                r_state <= S_B1;
                            end else begin
                                r_state <= S_DROP;
                            end
                        end
                    end
                    S_B1: begin
                        if (bus.RxEOP) begin
                            r_err   <= 1'b1;
                            r_state <= S_CHECK;
                        end else if (bus.RxDataValid) begin
                            r_b1    <= bus.RxData;
                            r_state <= S_B2;
                        end
                    end
                    S_B2: begin
                        if (bus.RxEOP) begin
                            r_err   <= 1'b1;
                            r_state <= S_CHECK;
                        end else if (bus.RxDataValid) begin
                            r_b2    <= bus.RxData;
                            r_state <= S_WAIT_EOP;
                        end
                    end
                    S_WAIT_EOP: begin
                        if (bus.RxEOP) begin
                            r_err   <= r_err | bus.RxBitStuffErr;
                            r_state <= S_CHECK;
                        end else if (bus.RxDataValid) begin
                            r_err <= 1'b1;
                        end
                    end
                    // Priority: error, SOF, address/enable filter, endpoint range, accept.
                    S_CHECK: begin
                        r_state <= S_IDLE;
                        if (r_err || !w_crcOk) begin
                            r_tokenErr <= 1'b1;
                        end else if (r_pid == PID_SOF) begin
                            r_SOFRxed  <= 1'b1;
                            r_frameNum <= w_field;
                        end else if (!bus.enable || (w_addr != bus.devAddr)) begin
                            r_tokenValid <= 1'b0;
                        end else if (int'(w_endp) >= NUM_ENDP) begin
                            r_endpMiss <= 1'b1;
                        end else begin
                            r_tokenValid <= 1'b1;
                            r_tokenPID   <= r_pid;
                            r_tokenEndP  <= w_endp;
                        end
                    end
                    S_DROP: begin
                        if (bus.RxEOP) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
`ifdef TOKEN_RX_SOF_TIMER_EN
            // A received SOF in the same cycle as expiry suppresses the synthetic frame advance.
            if (w_sofGood) begin
                r_sofTimer <= '0;
            end else if (r_sofTimer == 16'(SOF_TIMEOUT - 1)) begin
                r_sofTimer  <= '0;
                r_sofMissed <= 1'b1;
                r_frameNum  <= r_frameNum + 11'd1;
            end else begin
                r_sofTimer <= r_sofTimer + 16'd1;
            end
`endif
        end
    end

    assign bus.tokenValid = r_tokenValid;
    assign bus.tokenPID   = r_tokenPID;
    assign bus.tokenEndP  = r_tokenEndP;
    assign bus.SOFRxed    = r_SOFRxed;
    assign bus.frameNum   = r_frameNum;
    assign bus.tokenErr   = r_tokenErr;
    assign bus.endpMiss   = r_endpMiss;

endmodule

// File: tb/tb_slave_token_receiver.sv
// Directed scoreboard bench for slave_token_receiver; defining TOKEN_RX_SOF_TIMER_EN runs the SOF watchdog scenario.
module tb_slave_token_receiver;

    localparam int NUM_ENDP = 4;
`ifdef TOKEN_RX_SOF_TIMER_EN
    localparam int SOF_TIMEOUT = 100;
`else
    localparam int SOF_TIMEOUT = 60500;
`endif

    typedef logic [7:0] pkt_t [4];
    typedef enum int {K_NONE, K_VALID, K_SOF, K_ERR, K_MISS} kind_t;
    typedef struct {
        string       tag;
        logic [4:0]  strobes;
        logic [3:0]  pid;
        logic [3:0]  endp;
        logic [10:0] frame;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    slave_token_receiver_if bus();

    slave_token_receiver #(
        .NUM_ENDP    (NUM_ENDP),
        .SOF_TIMEOUT (SOF_TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    exp_t        sbQ[$];
    logic [3:0]  modelPid   = '0;
    logic [3:0]  modelEndp  = '0;
    logic [10:0] modelFrame = '0;
    pkt_t        pkt;

    function automatic logic [4:0] crcResidual(input logic [7:0] b1, input logic [7:0] b2);
        logic [4:0]  c;
        logic [15:0] d;
        logic        fb;
        c = 5'h1F;
        d = {b2, b1};
        for (int i = 0; i < 16; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
        end
        return c;
    endfunction

    // Search the five CRC bits that make the packet's residual come out right.
    function automatic pkt_t buildToken(input logic [3:0] pid, input logic [10:0] field);
        pkt_t p;
        p[0] = {~pid, pid};
        p[1] = field[7:0];
        p[2] = {5'b00000, field[10:8]};
        p[3] = 8'h00;
        for (int k = 0; k < 32; k++) begin
            if (crcResidual(p[1], {5'(k), field[10:8]}) == 5'b01100) begin
                p[2] = {5'(k), field[10:8]};
            end
        end
        return p;
    endfunction

    function automatic logic [4:0] dutStrobes();
        return {bus.tokenValid, bus.SOFRxed, bus.tokenErr, bus.endpMiss, bus.sofMissed};
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("[TB] comparison %s did not hold", tag);
        end
    endtask

    task automatic pushExpect(input string tag, input kind_t k, input logic [3:0] pid,
                              input logic [3:0] endp, input logic [10:0] frame);
        exp_t e;
        e.tag = tag;
        case (k)
            K_VALID: begin e.strobes = 5'b10000; modelPid = pid; modelEndp = endp; end
            K_SOF:   begin e.strobes = 5'b01000; modelFrame = frame; end
            K_ERR:   e.strobes = 5'b00100;
            K_MISS:  e.strobes = 5'b00010;
            default: e.strobes = 5'b00000;
        endcase
        e.pid   = modelPid;
        e.endp  = modelEndp;
        e.frame = modelFrame;
        sbQ.push_back(e);
    endtask

    task automatic drvSop();
        bus.RxSOP = 1'b1;
        @(posedge clk); #1;
        bus.RxSOP = 1'b0;
    endtask

    task automatic drvByte(input logic [7:0] b);
        bus.RxData      = b;
        bus.RxDataValid = 1'b1;
        @(posedge clk); #1;
        bus.RxDataValid = 1'b0;
    endtask

    task automatic drvEop(input logic bs);
        bus.RxEOP         = 1'b1;
        bus.RxBitStuffErr = bs;
        @(posedge clk); #1;
        bus.RxEOP         = 1'b0;
        bus.RxBitStuffErr = 1'b0;
    endtask

    task automatic applyStimulus(input pkt_t p, input int n, input logic bs);
        drvSop();
        for (int i = 0; i < n; i++) drvByte(p[i]);
        drvEop(bs);
    endtask

    // Called right after the EOP cycle: strobe must be absent one clk later, present two clk later, then gone.
    task automatic checkOutput();
        exp_t e;
        @(negedge clk);
        checkValue("strobeEarly", 32'(dutStrobes()), 32'h0);
        @(negedge clk);
        if (sbQ.size() == 0) begin
            checkValue("scoreboardEmpty", 32'(sbQ.size()), 32'd1);
        end else begin
            e = sbQ.pop_front();
            checkValue({e.tag, ".strobes"}, 32'(dutStrobes()), 32'(e.strobes));
            checkValue({e.tag, ".tokenPID"}, 32'(bus.tokenPID), 32'(e.pid));
            checkValue({e.tag, ".tokenEndP"}, 32'(bus.tokenEndP), 32'(e.endp));
            checkValue({e.tag, ".frameNum"}, 32'(bus.frameNum), 32'(e.frame));
        end
        @(negedge clk);
        checkValue("strobeAfter", 32'(dutStrobes()), 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic checkResetState(input string tag);
        checkValue({tag, ".strobes"}, 32'(dutStrobes()), 32'h0);
        checkValue({tag, ".tokenPID"}, 32'(bus.tokenPID), 32'h0);
        checkValue({tag, ".tokenEndP"}, 32'(bus.tokenEndP), 32'h0);
        checkValue({tag, ".frameNum"}, 32'(bus.frameNum), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        bus.RxData        = 8'h00;
        bus.RxDataValid   = 1'b0;
        bus.RxSOP         = 1'b0;
        bus.RxEOP         = 1'b0;
        bus.RxBitStuffErr = 1'b0;
        bus.devAddr       = 7'd0;
        bus.enable        = 1'b1;
        rst               = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetState("reset");
        @(posedge clk); #1;
        rst = 1'b1;

`ifdef TOKEN_RX_SOF_TIMER_EN
        begin
            int n;
            pkt = buildToken(4'h5, 11'h7FF);
            pushExpect("sof7FF", K_SOF, 4'h0, 4'h0, 11'h7FF);
            applyStimulus(pkt, 3, 1'b0);
            checkOutput();
            n = 0;
            while (!bus.sofMissed && n < 300) begin
                @(negedge clk);
                n++;
            end
            checkValue("sofMissedSeen", 32'(bus.sofMissed), 32'h1);
            checkValue("sofMissedTiming", 32'(n >= 95 && n <= 101), 32'h1);
            checkValue("frameWrap", 32'(bus.frameNum), 32'h000);
            @(negedge clk);
            checkValue("sofMissedPulse", 32'(bus.sofMissed), 32'h0);
            @(posedge clk); #1;
        end
`else
        pkt = '{8'h2D, 8'h00, 8'h10, 8'h00};
        pushExpect("setupAddr0", K_VALID, 4'hD, 4'h0, 11'h0);
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();

        bus.devAddr = 7'd5;
        pkt = '{8'h69, 8'h00, 8'h10, 8'h00};
        pushExpect("inWrongAddr", K_NONE, 4'h0, 4'h0, 11'h0);
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();

        bus.enable = 1'b0;
        pkt = '{8'hA5, 8'h00, 8'h10, 8'h00};
        pushExpect("sofDisabled", K_SOF, 4'h0, 4'h0, 11'h000);
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();

        bus.enable = 1'b1;
        pkt = buildToken(4'h9, {4'd3, 7'd5});
        pushExpect("inAddr5Ep3", K_VALID, 4'h9, 4'h3, 11'h0);
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();

        pkt = buildToken(4'h1, {4'd4, 7'd5});
        pushExpect("outEp4Miss", K_MISS, 4'h0, 4'h0, 11'h0);
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();

        pkt = buildToken(4'h1, {4'd2, 7'd6});
        pushExpect("outAddr6", K_NONE, 4'h0, 4'h0, 11'h0);
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();

        pkt = buildToken(4'h5, 11'h2A5);
        pushExpect("sof2A5", K_SOF, 4'h0, 4'h0, 11'h2A5);
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();

        bus.enable = 1'b0;
        pkt = buildToken(4'h9, {4'd1, 7'd5});
        pushExpect("inDisabled", K_NONE, 4'h0, 4'h0, 11'h0);
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();

        bus.enable  = 1'b1;
        bus.devAddr = 7'd0;
        pkt = '{8'h2D, 8'h00, 8'h11, 8'h00};
        pushExpect("crcErr", K_ERR, 4'h0, 4'h0, 11'h0);
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();

        pkt = '{8'h2E, 8'h00, 8'h10, 8'h00};
        pushExpect("pidErr", K_ERR, 4'h0, 4'h0, 11'h0);
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();

        pkt = '{8'h2D, 8'h00, 8'h10, 8'h00};
        pushExpect("lengthErr", K_ERR, 4'h0, 4'h0, 11'h0);
        applyStimulus(pkt, 4, 1'b0);
        checkOutput();

        pushExpect("bitStuffErr", K_ERR, 4'h0, 4'h0, 11'h0);
        applyStimulus(pkt, 3, 1'b1);
        checkOutput();

        pushExpect("shortPacket", K_ERR, 4'h0, 4'h0, 11'h0);
        applyStimulus(pkt, 2, 1'b0);
        checkOutput();

        // Restarted packet: the aborted SETUP must leave no trace.
        drvSop();
        drvByte(8'h2D);
        pushExpect("restartIn", K_VALID, 4'h9, 4'h0, 11'h0);
        pkt = '{8'h69, 8'h00, 8'h10, 8'h00};
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();

        drvByte(8'h2D);
        pkt = '{8'hC3, 8'h5A, 8'h10, 8'h00};
        pushExpect("data0Drop", K_NONE, 4'h0, 4'h0, 11'h0);
        applyStimulus(pkt, 2, 1'b0);
        checkOutput();

        pkt = '{8'h2D, 8'h00, 8'h10, 8'h00};
        pushExpect("afterDrop", K_VALID, 4'hD, 4'h0, 11'h0);
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();

        drvSop();
        drvByte(8'h2D);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checkResetState("midPacketReset");
        @(posedge clk); #1;
        modelPid   = '0;
        modelEndp  = '0;
        modelFrame = '0;
        pushExpect("afterReset", K_VALID, 4'hD, 4'h0, 11'h0);
        applyStimulus(pkt, 3, 1'b0);
        checkOutput();
`endif

        checkValue("scoreboardDrained", 32'(sbQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
